sprite_cmd_dispatcher: RTL

Upstream stage for the sprite display components (coin, and siblings sharing the 32-bit command bus). It accepts command words from the CPU-side bus interface and buffers them in a FIFO. It drives them onto the shared writedata bus as single-cycle pulses. Buffer-switch commands are held until vertical blanking, so the active sprite buffer never flips mid-frame.

---
 rtl/sprite_cmd_dispatcher.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sprite_cmd_dispatcher.sv
// Buffers CPU command words and replays them onto the sprite writedata bus,
// holding buffer-swap words until vertical blanking (one swap per vblank).
module sprite_cmd_dispatcher #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [9:0]  VBLANK_START = 10'd480,
    parameter logic [3:0]  SWAP_CODE    = 4'hF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [31:0]                   in_data,
    output logic                          in_ready,
    input  logic [9:0]                    hcount,
    input  logic [9:0]                    vcount,
    output logic [31:0]                   writedata,
    output logic                          swap_pending,
    output logic [7:0]                    swap_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ISSUE_CHECK = 2'd1;
    localparam logic [1:0] WAIT_VBLANK = 2'd2;
    localparam logic [1:0] GAP         = 2'd3;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_nxt;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             swap_armed;
    logic [31:0]      head;
    logic             push;
    logic             pop;
    logic             issue_swap;
    logic [31:0]      wd_nxt;
    logic             in_vblank;
    logic             frame_start;

    assign head        = mem[rd_ptr];
    assign push        = in_valid & in_ready;
    assign in_vblank   = (vcount >= VBLANK_START);
    // Top-left pixel of a frame; always outside vblank, so it simply re-arms.
    assign frame_start = (vcount == 10'd0) && (hcount == 10'd0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and issue decisions
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        issue_swap = 1'b0;
        wd_nxt     = 32'd0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    state_nxt = ISSUE_CHECK;
                end
            end
            ISSUE_CHECK: begin
                if (head[20:17] != SWAP_CODE) begin
                    pop       = 1'b1;
                    wd_nxt    = head;
                    state_nxt = GAP;
                end else begin
                    state_nxt = WAIT_VBLANK;
                end
            end
            WAIT_VBLANK: begin
                if (in_vblank && swap_armed) begin
                    pop        = 1'b1;
                    issue_swap = 1'b1;
                    wd_nxt     = head;
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LVL_W'(1);
        end else if (pop && !push) begin
            level_nxt = fifo_level - LVL_W'(1);
        end
    end

    // Storage has no reset; occupancy is tracked by the pointers and level
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            in_ready     <= 1'b1;
            writedata    <= 32'd0;
            swap_pending <= 1'b0;
            swap_count   <= 8'd0;
            swap_armed   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level   <= level_nxt;
            in_ready     <= (level_nxt < LVL_W'(FIFO_DEPTH));
            writedata    <= wd_nxt;
            swap_pending <= (state_nxt == WAIT_VBLANK);
            if (issue_swap) begin
                swap_count <= swap_count + 8'd1;
                swap_armed <= 1'b0;
            end else if (!in_vblank || frame_start) begin
                swap_armed <= 1'b1;
            end
        end
    end

endmodule
